// File: rtl/pattern_blinker_pkg.sv
// Shared types, default parameters and width helpers for the pattern blinker.
package pattern_blinker_pkg;

  localparam int unsigned DEFAULT_CHANNELS    = 4;
  localparam int unsigned DEFAULT_PATTERN_LEN = 35;
  localparam int unsigned DEFAULT_TICK_DIV    = 2000000;

  // Per-channel playback state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PLAYING = 2'd2
  } chan_state_e;

  // Bits needed to index n items, never less than one
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/pattern_blinker_channel.sv
// One LED channel: latches a pattern on load and replays it MSB-first, one bit per tick.
module pattern_blinker_channel
  import pattern_blinker_pkg::*;
#(
  parameter int unsigned PATTERN_LEN = DEFAULT_PATTERN_LEN
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               tick_i,
  input  logic                               load_i,
  input  logic [PATTERN_LEN-1:0]             pattern_i,
  input  logic [$clog2(PATTERN_LEN+1)-1:0]   len_i,
  input  logic                               loop_i,
  output logic                               led_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int unsigned LW = 32'($clog2(PATTERN_LEN + 1));
  localparam int unsigned IW = idx_width(PATTERN_LEN);

  chan_state_e            state_q;
  logic [PATTERN_LEN-1:0] pattern_q;
  logic [LW-1:0]          len_q;
  logic                   loop_q;
  logic [IW-1:0]          idx_q;
  logic                   led_q;
  logic                   busy_q;
  logic                   done_q;

  logic [IW-1:0]          last_idx_c;
  logic [IW-1:0]          prev_idx_c;

  // Index of the first-played bit and of the bit following the current one
  assign last_idx_c = IW'(len_q - LW'(1));
  assign prev_idx_c = idx_q - IW'(1);

  // Playback FSM; a load always takes priority over a coincident tick
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      idx_q     <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        led_q <= 1'b0;
        idx_q <= '0;
        if (len_i == '0) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end else begin
          state_q   <= ST_ARMED;
          busy_q    <= 1'b1;
          pattern_q <= pattern_i;
          len_q     <= len_i;
          loop_q    <= loop_i;
        end
      end else if (tick_i) begin
        case (state_q)
          ST_ARMED: begin
            state_q <= ST_PLAYING;
            idx_q   <= last_idx_c;
            led_q   <= pattern_q[last_idx_c];
          end
          ST_PLAYING: begin
            if (idx_q != '0) begin
              idx_q <= prev_idx_c;
              led_q <= pattern_q[prev_idx_c];
            end else if (loop_q) begin
              // Wrap straight to the first bit so repeats have no gap
              idx_q <= last_idx_c;
              led_q <= pattern_q[last_idx_c];
            end else begin
              state_q <= ST_IDLE;
              led_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/pattern_blinker.sv
// Multi-channel LED pattern sequencer: shared prescaler, load decode and per-channel players.
module pattern_blinker
  import pattern_blinker_pkg::*;
#(
  parameter int unsigned CHANNELS    = DEFAULT_CHANNELS,
  parameter int unsigned PATTERN_LEN = DEFAULT_PATTERN_LEN,
  parameter int unsigned TICK_DIV    = DEFAULT_TICK_DIV
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [idx_width(CHANNELS)-1:0]     load_chan,
  input  logic [PATTERN_LEN-1:0]             load_pattern,
  input  logic [$clog2(PATTERN_LEN+1)-1:0]   load_len,
  input  logic                               load_loop,
  output logic [CHANNELS-1:0]                led_out,
  output logic [CHANNELS-1:0]                busy,
  output logic [CHANNELS-1:0]                done_pulse
);

  localparam int unsigned CW = idx_width(CHANNELS);
  localparam int unsigned LW = 32'($clog2(PATTERN_LEN + 1));
  localparam int unsigned PW = idx_width(TICK_DIV);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick_c;
  logic          load_ready_q;
  logic          accept_c;
  logic [LW-1:0] len_clamped_c;

  // Single-cycle tick at the top of each prescaler period
  assign tick_c = (presc_q == PW'(TICK_DIV - 1));

  // Prescaler next value: wrap on tick
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (tick_c) begin
      presc_d = '0;
    end
  end

  // Free-running prescaler shared by all channels
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Ready is held low in reset and high otherwise; one load per cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      load_ready_q <= 1'b0;
    end else begin
      load_ready_q <= 1'b1;
    end
  end

  assign load_ready = load_ready_q;
  assign accept_c   = load_valid & load_ready_q;

  // Lengths beyond the pattern storage are played as full-length patterns
  assign len_clamped_c = (32'(load_len) > PATTERN_LEN) ? LW'(PATTERN_LEN) : load_len;

  // Channel array; an out-of-range load_chan matches no channel and is dropped
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic load_hit_c;

    assign load_hit_c = accept_c && (load_chan == CW'(g));

    pattern_blinker_channel #(
      .PATTERN_LEN (PATTERN_LEN)
    ) u_chan (
      .clk_i     (CLK),
      .rst_i     (RST),
      .tick_i    (tick_c),
      .load_i    (load_hit_c),
      .pattern_i (load_pattern),
      .len_i     (len_clamped_c),
      .loop_i    (load_loop),
      .led_o     (led_out[g]),
      .busy_o    (busy[g]),
      .done_o    (done_pulse[g])
    );
  end

endmodule
